// File: rtl/vx_csr_access_pipe_pkg.sv
// Shared definitions for the CSR access pipe: op encodings, FP CSR addresses,
// address classification helpers and the S1 entry layout.
package vx_csr_access_pipe_pkg;

    typedef enum logic [1:0] {
        CsrOpIll = 2'b00,
        CsrOpRw  = 2'b01,
        CsrOpRs  = 2'b10,
        CsrOpRc  = 2'b11
    } csr_op_e;

    localparam logic [11:0] CsrFflags = 12'h001;
    localparam logic [11:0] CsrFrm    = 12'h002;
    localparam logic [11:0] CsrFcsr   = 12'h003;

    function automatic logic read_only(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

    // FFLAGS/FRM/FCSR are views of the same physical bits in the store.
    function automatic logic fp_alias(input logic [11:0] addr);
        return (addr == CsrFflags) || (addr == CsrFrm) || (addr == CsrFcsr);
    endfunction

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] old_data;
        logic [31:0] new_data;
        logic        we;
        logic        illegal;
    } s1_entry_t;

endpackage

// File: rtl/vx_csr_access_pipe_rmw_alu.sv
// Combinational read-modify-write for one CSR instruction: computes the new
// value, whether the store is actually written, and whether the access is illegal.
module vx_csr_access_pipe_rmw_alu
    import vx_csr_access_pipe_pkg::*;
(
    input  logic [31:0] old_data,
    input  logic [31:0] src,
    input  logic [1:0]  op,
    input  logic        src_zero,
    input  logic [11:0] addr,
    output logic [31:0] new_data,
    output logic        we,
    output logic        illegal
);

    logic writes_intent;
    logic ro;

    always_comb begin
        new_data = old_data;
        unique case (op)
            CsrOpRw:  new_data = src;
            CsrOpRs:  new_data = old_data | src;
            CsrOpRc:  new_data = old_data & ~src;
            default:  new_data = old_data;
        endcase
    end

    // RS/RC with a zero source are pure reads and never count as writes.
    assign writes_intent = (op == CsrOpRw) | ~src_zero;
    assign ro            = read_only(addr);
    assign we            = (op != CsrOpIll) & writes_intent & ~ro;
    assign illegal       = (op == CsrOpIll) | (ro & writes_intent);

endmodule

// File: rtl/vx_csr_access_pipe.sv
// One-entry CSR read-modify-write pipe in front of the per-core CSR store,
// with read-after-write forwarding and a one-cycle stall on FP CSR alias hazards.
module vx_csr_access_pipe
    import vx_csr_access_pipe_pkg::*;
#(
    parameter int          CORE_ID = 0,
    parameter int unsigned NW_BITS = 2,
    parameter int unsigned TAG_W   = 8
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               req_valid,
    output logic               req_ready,
    input  logic [NW_BITS-1:0] req_wid,
    input  logic [TAG_W-1:0]   req_tag,
    input  logic [1:0]         req_op,
    input  logic [11:0]        req_addr,
    input  logic [31:0]        req_src,
    input  logic               req_src_zero,

    output logic               csr_read_enable,
    output logic [11:0]        csr_read_addr,
    output logic [NW_BITS-1:0] csr_read_wid,
    input  logic [31:0]        csr_read_data,

    output logic               csr_write_enable,
    output logic [11:0]        csr_write_addr,
    output logic [NW_BITS-1:0] csr_write_wid,
    output logic [31:0]        csr_write_data,

    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [NW_BITS-1:0] rsp_wid,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic [31:0]        rsp_data,
    output logic               rsp_illegal,

    output logic               pending
);

    logic               unused_core_id;
    assign unused_core_id = ^32'(CORE_ID);

    logic               s1_valid_q, s1_valid_d;
    logic               s1_wr_pending_q, s1_wr_pending_d;
    s1_entry_t          s1_q, s1_d;
    logic [NW_BITS-1:0] s1_wid_q, s1_wid_d;
    logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;

    logic               s1_write_live;
    logic               same_wid;
    logic               forward_hit;
    logic               alias_stall;
    logic               fire;
    logic               rsp_fire;
    logic [31:0]        old_data;
    logic [31:0]        new_data;
    logic               alu_we;
    logic               alu_illegal;

    // S1 only holds a write that the store has not absorbed yet on its first cycle.
    assign s1_write_live = s1_valid_q & s1_wr_pending_q & s1_q.we;
    assign same_wid      = (s1_wid_q == req_wid);
    assign forward_hit   = s1_write_live & same_wid & (s1_q.addr == req_addr);
    assign alias_stall   = s1_write_live & same_wid & fp_alias(s1_q.addr) & fp_alias(req_addr)
                         & (s1_q.addr != req_addr);

    assign req_ready = reset & (~s1_valid_q | rsp_ready) & ~alias_stall;
    assign fire      = req_valid & req_ready;
    assign rsp_fire  = s1_valid_q & rsp_ready;

    assign old_data = forward_hit ? s1_q.new_data : csr_read_data;

    vx_csr_access_pipe_rmw_alu u_rmw_alu (
        .old_data (old_data),
        .src      (req_src),
        .op       (req_op),
        .src_zero (req_src_zero),
        .addr     (req_addr),
        .new_data (new_data),
        .we       (alu_we),
        .illegal  (alu_illegal)
    );

    always_comb begin
        s1_valid_d      = s1_valid_q;
        s1_wr_pending_d = 1'b0;
        s1_d            = s1_q;
        s1_wid_d        = s1_wid_q;
        s1_tag_d        = s1_tag_q;
        if (fire) begin
            s1_valid_d        = 1'b1;
            s1_wr_pending_d   = 1'b1;
            s1_d.addr         = req_addr;
            s1_d.old_data     = old_data;
            s1_d.new_data     = new_data;
            s1_d.we           = alu_we;
            s1_d.illegal      = alu_illegal;
            s1_wid_d          = req_wid;
            s1_tag_d          = req_tag;
        end else if (rsp_fire) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q      <= 1'b0;
            s1_wr_pending_q <= 1'b0;
            s1_q            <= '0;
            s1_wid_q        <= '0;
            s1_tag_q        <= '0;
        end else begin
            s1_valid_q      <= s1_valid_d;
            s1_wr_pending_q <= s1_wr_pending_d;
            s1_q            <= s1_d;
            s1_wid_q        <= s1_wid_d;
            s1_tag_q        <= s1_tag_d;
        end
    end

    assign csr_read_enable = fire;
    assign csr_read_addr   = reset ? req_addr : 12'h000;
    assign csr_read_wid    = reset ? req_wid : '0;

    assign csr_write_enable = s1_write_live;
    assign csr_write_addr   = s1_q.addr;
    assign csr_write_wid    = s1_wid_q;
    assign csr_write_data   = s1_q.new_data;

    assign rsp_valid   = s1_valid_q;
    assign rsp_wid     = s1_wid_q;
    assign rsp_tag     = s1_tag_q;
    assign rsp_data    = s1_q.old_data;
    assign rsp_illegal = s1_q.illegal;
    assign pending     = s1_valid_q;

endmodule

// File: doc/vx_csr_access_pipe.md
# VX_csr_access_pipe

Upstream feeder of the per-core CSR data store. Accepts decoded CSR instructions (CSRRW/CSRRS/CSRRC and immediate forms) from the CSR issue path, performs the read-modify-write against the store's combinational read port and registered write port, and returns the old CSR value to writeback. It is a one-entry pipeline with full throughput, read-after-write forwarding and FP-CSR alias stalling, so back-to-back CSR instructions see architecturally correct values.

## Interface
- CORE_ID, 0, core index, passed through for debug messages only
- NW_BITS, 2, warp-id width
- TAG_W, 8, opaque instruction tag (uuid/rd), returned unchanged
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid & ready
- req_wid  in  NW_BITS  warp id
- req_tag  in  TAG_W  tag
- req_op  in  2  01 RW, 10 RS, 11 RC, 00 illegal
- req_addr  in  12  CSR address
- req_src  in  32  rs1 value or zero-extended uimm
- req_src_zero  in  1  rs1==x0 / uimm==0
- csr_read_enable  out  1  = req_valid & req_ready
- csr_read_addr  out  12  = req_addr
- csr_read_wid  out  NW_BITS  = req_wid
- csr_read_data  in  32  combinational read result
- csr_write_enable  out  1  one-cycle write strobe
- csr_write_addr  out  12
- csr_write_wid  out  NW_BITS
- csr_write_data  out  32
- rsp_valid  out  1
- rsp_ready  in  1
- rsp_wid  out  NW_BITS
- rsp_tag  out  TAG_W
- rsp_data  out  32  old CSR value
- rsp_illegal  out  1  op 00, or write attempted to read-only CSR
- pending  out  1  entry held in S1

## Operation
- S0 (accept): on fire, old = forward_hit ? s1_new : csr_read_data. forward_hit = s1_wr_pending & s1_we & addr/wid equal.
- new = RW: src; RS: old | src; RC: old & ~src.
- we = op!=00 & (op==01 | ~src_zero) & ~read_only(addr); read_only = addr[11:10]==2'b11.
- illegal = op==00 | (read_only(addr) & (op==01 | ~src_zero)).
- S1 register captures wid, tag, addr, old, new, we, illegal; sets s1_valid, s1_wr_pending.
- Write issued exactly once: csr_write_enable = s1_valid & s1_wr_pending & s1_we; wr_pending clears next cycle regardless of rsp_ready.
- req_ready = ~s1_valid | rsp_ready, forced 0 on alias stall: s1_wr_pending & s1_we & same wid & both addrs in {0x001,0x002,0x003} & addrs differ.
- S1 clears on rsp fire without new accept; reloads on simultaneous rsp fire + accept.
- rsp_* driven directly from S1; rsp_valid = s1_valid.

## Timing
- Latency 1: accept at cycle N -> rsp_valid and csr_write_enable at N+1.
- Throughput 1/cycle with rsp_ready held high; alias stall costs exactly 1 cycle.
- rsp_* stable while rsp_valid & ~rsp_ready.
- Reset (async, active-low): s1_valid=0, s1_wr_pending=0; req_ready=0, rsp_valid=0, csr_write_enable=0, csr_read_enable=0, pending=0, all data outputs 0. Reset mid-operation drops S1; no write issued for the dropped entry.
- Stalled S1 (rsp_ready low) after its write cycle needs no forwarding: store already updated.

## Structure
- Shared package VX_csr_pkg: op encodings, CSR_FFLAGS/FRM/FCSR addresses, read_only() and fp_alias() functions, S1 entry struct.
- Sub-module VX_csr_rmw_alu: combinational old/src/op/src_zero/addr -> new, we, illegal.

## Test plan
- Reset then RW 0x300 src 0x8 with store 0x0 -> N+1: write 0x300=0x8, rsp_data 0x0, illegal 0.
- Back-to-back RS 0x300 src 0x1 then RS 0x300 src 0x2, store 0x0 -> rsp_data 0x0 then 0x1 (forwarded), writes 0x1 then 0x3.
- RS 0xC00 (cycle) src_zero=1 -> no write, rsp_data=store value, illegal 0; RW 0xC00 -> no write, illegal 1.
- FCSR RW src 0xE5 then FFLAGS RS, same wid -> one-cycle req_ready=0, FFLAGS rsp_data 0x05.
- rsp_ready low 3 cycles -> single csr_write_enable pulse, rsp_* stable, req_ready=0.
- Reset asserted in cycle after accept -> rsp_valid=0, no write strobe.
